// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - command sequencer between keypad decoder and X/Y register file / ALU
module calc_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [1:0]  op_code,
    input  logic [1:0]  op_fn,
    input  logic [15:0] op_data,
    output logic        op_ready,
    output logic        rf_we,
    output logic        rf_addr,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata,
    output logic        alu_start,
    output logic [1:0]  alu_fn,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic        alu_err,
    input  logic [15:0] alu_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE, WR, CLR_X, CLR_Y, RD_X, RD_Y, EXEC, WAIT, WB, DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;

    assign op_ready = (state == IDLE);

    // rf_addr/rf_we are set one state ahead so they are valid for the whole
    // cycle of the state that uses them (the read port is combinational).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rf_we        <= 1'b0;
            rf_addr      <= 1'b0;
            rf_wdata     <= '0;
            alu_start    <= 1'b0;
            alu_fn       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        err <= 1'b0;
                        case (op_code)
                            2'b00, 2'b01: begin
                                state    <= WR;
                                rf_we    <= 1'b1;
                                rf_addr  <= op_code[0];
                                rf_wdata <= op_data;
                            end
                            2'b10: begin
                                state   <= RD_X;
                                rf_addr <= 1'b0;
                                alu_fn  <= op_fn;
                            end
                            default: begin
                                state    <= CLR_X;
                                rf_we    <= 1'b1;
                                rf_addr  <= 1'b0;
                                rf_wdata <= '0;
                            end
                        endcase
                    end
                end
                WR: begin
                    state   <= IDLE;
                    rf_we   <= 1'b0;
                    rf_addr <= 1'b0;
                end
                CLR_X: begin
                    state   <= CLR_Y;
                    rf_addr <= 1'b1;
                end
                CLR_Y: begin
                    state   <= IDLE;
                    rf_we   <= 1'b0;
                    rf_addr <= 1'b0;
                end
                RD_X: begin
                    state   <= RD_Y;
                    alu_a   <= rf_rdata;
                    rf_addr <= 1'b1;
                end
                RD_Y: begin
                    state     <= EXEC;
                    alu_b     <= rf_rdata;
                    rf_addr   <= 1'b0;
                    alu_start <= 1'b1;
                end
                EXEC: begin
                    state     <= WAIT;
                    alu_start <= 1'b0;
                    wait_cnt  <= '0;
                end
                WAIT: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            err          <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            result   <= alu_result;
                            rf_wdata <= alu_result;
                            rf_we    <= 1'b1;
                            rf_addr  <= 1'b0;
                            state    <= WB;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            err          <= 1'b1;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                WB: begin
                    state        <= DONE;
                    rf_we        <= 1'b0;
                    result_valid <= 1'b1;
                end
                DONE: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - table-driven and randomized check of calc_sequencer
module tb_calc_sequencer;

    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [1:0]  op_fn;
    logic [15:0] op_data;
    logic        op_ready;
    logic        rf_we;
    logic        rf_addr;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata;
    logic        alu_start;
    logic [1:0]  alu_fn;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done;
    logic        alu_err;
    logic [15:0] alu_result;
    logic [15:0] result;
    logic        result_valid;
    logic        err;

    calc_sequencer #(.TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_code(op_code), .op_fn(op_fn), .op_data(op_data),
        .op_ready(op_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .alu_start(alu_start), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
        .result(result), .result_valid(result_valid), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file without reset, combinational read
    logic [15:0] rf_mem [2];
    always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_addr];

    int n_vec = 0;
    int n_bad = 0;

    int          lat, nwr, nrv, nstart;
    logic [15:0] cap_a, cap_b;
    logic [1:0]  cap_fn;
    logic        wr_addr [4];
    logic [15:0] wr_data [4];
    int          wr_cyc  [4];

    typedef struct {
        logic [1:0]  code;
        logic [1:0]  fn;
        logic [15:0] data;
        int          dly;
        bit          poke;
        int          lat;
        int          nwr;
        logic [15:0] res;
        logic        er;
        logic [15:0] x;
        logic [15:0] y;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] alu_f(input logic [1:0] fn, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (fn)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin p = a * b; return p[15:0]; end
            default: return (b == 16'd0) ? 16'd0 : a / b;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_op_ready"}, op_ready, 1'b1);
        chk({tag, "_rf_we"}, rf_we, 1'b0);
        chk({tag, "_rf_addr"}, rf_addr, 1'b0);
        chk({tag, "_rf_wdata"}, rf_wdata, 16'h0);
        chk({tag, "_alu_start"}, alu_start, 1'b0);
        chk({tag, "_alu_fn"}, alu_fn, 2'b0);
        chk({tag, "_alu_a"}, alu_a, 16'h0);
        chk({tag, "_alu_b"}, alu_b, 16'h0);
        chk({tag, "_result"}, result, 16'h0);
        chk({tag, "_result_valid"}, result_valid, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    // dly < 0: ALU never answers; otherwise alu_done comes dly+1 cycles after alu_start
    task automatic run_cmd(input logic [1:0] code, input logic [1:0] fn, input logic [15:0] data,
                           input int dly, input bit poke);
        int cyc;
        int s;
        op_valid = 1'b1;
        op_code  = code;
        op_fn    = fn;
        op_data  = data;
        step();
        op_valid = 1'b0;
        cyc = 1; s = 0;
        nwr = 0; nrv = 0; nstart = 0;
        while (!op_ready && cyc < 200) begin
            if (rf_we) begin
                if (nwr < 4) begin
                    wr_addr[nwr] = rf_addr;
                    wr_data[nwr] = rf_wdata;
                    wr_cyc[nwr]  = cyc;
                end
                nwr++;
            end
            if (result_valid) nrv++;
            if (alu_start) begin
                nstart++;
                s = cyc;
                cap_a = alu_a; cap_b = alu_b; cap_fn = alu_fn;
            end
            alu_done = 1'b0;
            if (s > 0 && dly >= 0 && cyc == s + 1 + dly) begin
                alu_done   = 1'b1;
                alu_err    = (cap_fn == 2'd3) && (cap_b == 16'd0);
                alu_result = alu_f(cap_fn, cap_a, cap_b);
            end
            op_valid = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                op_code = 2'b00;
                op_data = 16'hABCD;
            end
            step();
            cyc++;
        end
        alu_done = 1'b0;
        op_valid = 1'b0;
        lat = cyc;
    endtask

    initial begin
        logic [15:0] mx, my, mres, ax, ay;
        logic        merr;
        int          e_lat, e_nwr, dly;
        logic [1:0]  code, fn;
        logic [15:0] data;
        bit          seen_we, seen_rv;

        tbl[0]  = '{2'b00, 2'd0, 16'h0012,  0, 1'b0,  2, 1, 16'h0000, 1'b0, 16'h0012, 16'h0000};
        tbl[1]  = '{2'b01, 2'd0, 16'h0034,  0, 1'b0,  2, 1, 16'h0000, 1'b0, 16'h0012, 16'h0034};
        tbl[2]  = '{2'b10, 2'd0, 16'h0000,  0, 1'b0,  7, 1, 16'h0046, 1'b0, 16'h0046, 16'h0034};
        tbl[3]  = '{2'b01, 2'd0, 16'h0000,  0, 1'b0,  2, 1, 16'h0046, 1'b0, 16'h0046, 16'h0000};
        tbl[4]  = '{2'b10, 2'd3, 16'h0000,  0, 1'b0,  6, 0, 16'h0046, 1'b1, 16'h0046, 16'h0000};
        tbl[5]  = '{2'b00, 2'd0, 16'h0012,  0, 1'b0,  2, 1, 16'h0046, 1'b0, 16'h0012, 16'h0000};
        tbl[6]  = '{2'b10, 2'd2, 16'h0000, -1, 1'b0, 13, 0, 16'h0046, 1'b1, 16'h0012, 16'h0000};
        tbl[7]  = '{2'b01, 2'd0, 16'h0003,  0, 1'b0,  2, 1, 16'h0046, 1'b0, 16'h0012, 16'h0003};
        tbl[8]  = '{2'b10, 2'd1, 16'h0000,  7, 1'b0, 14, 1, 16'h000F, 1'b0, 16'h000F, 16'h0003};
        tbl[9]  = '{2'b10, 2'd0, 16'h0000,  8, 1'b0, 13, 0, 16'h000F, 1'b1, 16'h000F, 16'h0003};
        tbl[10] = '{2'b00, 2'd0, 16'hFFFF,  0, 1'b0,  2, 1, 16'h000F, 1'b0, 16'hFFFF, 16'h0003};
        tbl[11] = '{2'b01, 2'd0, 16'h8000,  0, 1'b0,  2, 1, 16'h000F, 1'b0, 16'hFFFF, 16'h8000};
        tbl[12] = '{2'b11, 2'd0, 16'h0000,  0, 1'b1,  3, 2, 16'h000F, 1'b0, 16'h0000, 16'h0000};

        rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_fn = '0; op_data = '0;
        alu_done = 1'b0; alu_err = 1'b0; alu_result = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            run_cmd(tbl[i].code, tbl[i].fn, tbl[i].data, tbl[i].dly, tbl[i].poke);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_writes", nwr, tbl[i].nwr);
            chk("tbl_result_valid", nrv, (tbl[i].code == 2'b10) ? 1 : 0);
            chk("tbl_result", result, tbl[i].res);
            chk("tbl_err", err, tbl[i].er);
            chk("tbl_x", rf_mem[0], tbl[i].x);
            if (i > 0) chk("tbl_y", rf_mem[1], tbl[i].y);
            if (tbl[i].code == 2'b10) begin
                chk("tbl_alu_starts", nstart, 1);
                chk("tbl_alu_a", cap_a, tbl[i-1].x);
                chk("tbl_alu_b", cap_b, tbl[i-1].y);
                chk("tbl_alu_fn", cap_fn, tbl[i].fn);
            end else if (tbl[i].code == 2'b11) begin
                chk("clr_addr0", wr_addr[0], 1'b0);
                chk("clr_addr1", wr_addr[1], 1'b1);
                chk("clr_data0", wr_data[0], 16'h0);
                chk("clr_data1", wr_data[1], 16'h0);
                chk("clr_cyc0", wr_cyc[0], 1);
                chk("clr_cyc1", wr_cyc[1], 2);
            end else begin
                chk("load_addr", wr_addr[0], tbl[i].code[0]);
                chk("load_data", wr_data[0], tbl[i].data);
            end
        end

        mx = 16'h0; my = 16'h0; mres = tbl[12].res;
        for (int k = 0; k < 40; k++) begin
            code = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'($urandom_range(0, 3));
            fn   = 2'($urandom_range(0, 3));
            data = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            dly  = int'($urandom_range(0, 9));
            if (dly == 9) dly = -1;
            ax = mx; ay = my;
            run_cmd(code, fn, data, dly, 1'b0);
            case (code)
                2'b00, 2'b01: begin
                    e_lat = 2; e_nwr = 1; merr = 1'b0;
                    if (code[0]) my = data; else mx = data;
                end
                2'b10: begin
                    if (dly >= 0 && dly < T) begin
                        if (fn == 2'd3 && ay == 16'd0) begin
                            e_lat = 6 + dly; e_nwr = 0; merr = 1'b1;
                        end else begin
                            e_lat = 7 + dly; e_nwr = 1; merr = 1'b0;
                            mres = alu_f(fn, ax, ay);
                            mx = mres;
                        end
                    end else begin
                        e_lat = 5 + T; e_nwr = 0; merr = 1'b1;
                    end
                end
                default: begin
                    e_lat = 3; e_nwr = 2; merr = 1'b0;
                    mx = 16'h0; my = 16'h0;
                end
            endcase
            chk("rnd_latency", lat, e_lat);
            chk("rnd_writes", nwr, e_nwr);
            chk("rnd_result_valid", nrv, (code == 2'b10) ? 1 : 0);
            chk("rnd_result", result, mres);
            chk("rnd_err", err, merr);
            chk("rnd_x", rf_mem[0], mx);
            chk("rnd_y", rf_mem[1], my);
            if (code == 2'b10) begin
                chk("rnd_alu_a", cap_a, ax);
                chk("rnd_alu_b", cap_b, ay);
                chk("rnd_alu_fn", cap_fn, fn);
            end
        end

        // reset while waiting on the ALU, then a late alu_done
        run_cmd(2'b00, 2'd0, 16'h0102, 0, 1'b0);
        run_cmd(2'b01, 2'd0, 16'h0304, 0, 1'b0);
        op_valid = 1'b1; op_code = 2'b10; op_fn = 2'd2;
        step();
        op_valid = 1'b0;
        repeat (4) step();
        chk("rst_in_wait_busy", op_ready, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("rst_async_op_ready", op_ready, 1'b1);
        chk("rst_async_rf_we", rf_we, 1'b0);
        step();
        rst_n = 1'b1;
        alu_done = 1'b1; alu_err = 1'b0; alu_result = 16'h1234;
        seen_we = 1'b0; seen_rv = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            alu_done = 1'b0;
            seen_we |= rf_we;
            seen_rv |= result_valid;
        end
        chk("rst_no_write", seen_we, 1'b0);
        chk("rst_no_result_valid", seen_rv, 1'b0);
        check_reset_outputs("rst_mid");
        chk("rst_x_kept", rf_mem[0], 16'h0102);
        chk("rst_y_kept", rf_mem[1], 16'h0304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
